// File: rtl/nios_cpu_mult_seq_pkg.sv
// rtl/nios_cpu_mult_seq_pkg.sv - shared op codes, FSM states and helpers for the sequential multiplier
// Contents:
//   OP_MUL/OP_MULXUU/OP_MULXSU/OP_MULXSS : req_op encodings
//   state_e                              : sequencer FSM states
//   swap_halves()                        : exchange the 16-bit halves of a word
package nios_cpu_mult_seq_pkg;

  localparam logic [1:0] OP_MUL    = 2'd0;
  localparam logic [1:0] OP_MULXUU = 2'd1;
  localparam logic [1:0] OP_MULXSU = 2'd2;
  localparam logic [1:0] OP_MULXSS = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE_LO,
    ST_COMB_LO,
    ST_ISSUE_HI,
    ST_COMB_HI,
    ST_DONE
  } state_e;

  // The second cell pass feeds hi halves into the lo slots so p1 becomes hi1*hi2.
  function automatic logic [31:0] swap_halves(input logic [31:0] x);
    return {x[15:0], x[31:16]};
  endfunction

endpackage

// File: rtl/nios_cpu_mult_seq_if.sv
// rtl/nios_cpu_mult_seq_if.sv - request/response/cell bundle of the sequential multiplier
// Signals:
//   req_valid/req_ready/req_op/req_src1/req_src2 : request handshake and operands
//   rsp_valid/rsp_ready/rsp_data                 : response handshake and result
//   cell_src1/cell_src2/cell_en                  : operands and enable to the 16x16 cell
//   cell_p1/cell_p2/cell_p3                      : cell products lo1*lo2, lo1*hi2, hi1*lo2
// Modports: slave = multiplier, master = requester/cell side.
interface nios_cpu_mult_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [31:0] cell_src1;
  logic [31:0] cell_src2;
  logic        cell_en;
  logic [31:0] cell_p1;
  logic [31:0] cell_p2;
  logic [31:0] cell_p3;

  modport slave (
    input  req_valid, req_op, req_src1, req_src2, rsp_ready,
           cell_p1, cell_p2, cell_p3,
    output req_ready, rsp_valid, rsp_data, cell_src1, cell_src2, cell_en
  );

  modport master (
    output req_valid, req_op, req_src1, req_src2, rsp_ready,
           cell_p1, cell_p2, cell_p3,
    input  req_ready, rsp_valid, rsp_data, cell_src1, cell_src2, cell_en
  );
endinterface

// File: rtl/nios_cpu_mult_pp_combine.sv
// rtl/nios_cpu_mult_pp_combine.sv - combinational partial-product combine and signed correction
// Ports:
//   p1_i/p2_i/p3_i        : cell products of the current pass
//   op_i, src1_i, src2_i  : latched operation and operands
//   mid_hi_i, lo_c_i      : carry terms saved from the low pass
//   hi_i                  : registered unsigned high word awaiting correction
//   mid_hi_o, lo_c_o      : carry terms of the low pass
//   lo_o                  : low result word
//   hi_raw_o              : unsigned high word (second pass)
//   hi_corr_o             : hi_i with the signed correction applied
module nios_cpu_mult_pp_combine
  import nios_cpu_mult_seq_pkg::*;
(
  input  logic [31:0] p1_i,
  input  logic [31:0] p2_i,
  input  logic [31:0] p3_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  input  logic [16:0] mid_hi_i,
  input  logic        lo_c_i,
  input  logic [31:0] hi_i,
  output logic [16:0] mid_hi_o,
  output logic        lo_c_o,
  output logic [31:0] lo_o,
  output logic [31:0] hi_raw_o,
  output logic [31:0] hi_corr_o
);
  logic [32:0] mid;
  logic [32:0] lo;
  logic [31:0] corr1;
  logic [31:0] corr2;

  always_comb begin
    mid      = {1'b0, p2_i} + {1'b0, p3_i};
    lo       = {1'b0, p1_i} + {1'b0, mid[15:0], 16'h0000};
    mid_hi_o = mid[32:16];
    lo_c_o   = lo[32];
    lo_o     = lo[31:0];
    hi_raw_o = p1_i + {15'h0000, mid_hi_i} + {31'h0, lo_c_i};
    // A negative operand read as unsigned adds 2^32 * (other operand); remove it.
    corr1    = src1_i[31] ? src2_i : 32'h0;
    corr2    = src2_i[31] ? src1_i : 32'h0;
    hi_corr_o = hi_i;
    case (op_i)
      OP_MULXSU: hi_corr_o = hi_i - corr1;
      OP_MULXSS: hi_corr_o = hi_i - corr1 - corr2;
      default:   hi_corr_o = hi_i;
    endcase
  end
endmodule

// File: rtl/nios_cpu_mult_seq.sv
// rtl/nios_cpu_mult_seq.sv - sequential 32x32 multiplier built on an external 16x16 partial-product cell
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : slave side of nios_cpu_mult_seq_if (request, response and cell signals)
// Parameter CELL_LATENCY (1..3): enabled edges from operands to valid cell products.
module nios_cpu_mult_seq
  import nios_cpu_mult_seq_pkg::*;
#(
  parameter int unsigned CELL_LATENCY = 1
)
(
  input logic                clk,
  input logic                reset_n,
  nios_cpu_mult_seq_if.slave bus
);
  localparam logic [1:0] LAT_LAST = 2'(CELL_LATENCY - 1);

  state_e      state_q;
  logic [1:0]  op_q;
  logic [31:0] src1_q;
  logic [31:0] src2_q;
  logic [1:0]  cnt_q;
  logic [16:0] mid_hi_q;
  logic        lo_c_q;
  logic [31:0] hi_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_data_q;
  logic [31:0] cell_src1_q;
  logic [31:0] cell_src2_q;
  logic        cell_en_q;

  logic [16:0] mid_hi_d;
  logic        lo_c_d;
  logic [31:0] lo_d;
  logic [31:0] hi_raw_d;
  logic [31:0] hi_corr_d;

  nios_cpu_mult_pp_combine u_combine (
    .p1_i      (bus.cell_p1),
    .p2_i      (bus.cell_p2),
    .p3_i      (bus.cell_p3),
    .op_i      (op_q),
    .src1_i    (src1_q),
    .src2_i    (src2_q),
    .mid_hi_i  (mid_hi_q),
    .lo_c_i    (lo_c_q),
    .hi_i      (hi_q),
    .mid_hi_o  (mid_hi_d),
    .lo_c_o    (lo_c_d),
    .lo_o      (lo_d),
    .hi_raw_o  (hi_raw_d),
    .hi_corr_o (hi_corr_d)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      op_q        <= 2'd0;
      src1_q      <= 32'h0;
      src2_q      <= 32'h0;
      cnt_q       <= 2'd0;
      mid_hi_q    <= 17'h0;
      lo_c_q      <= 1'b0;
      hi_q        <= 32'h0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'h0;
      cell_src1_q <= 32'h0;
      cell_src2_q <= 32'h0;
      cell_en_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            op_q        <= bus.req_op;
            src1_q      <= bus.req_src1;
            src2_q      <= bus.req_src2;
            cell_src1_q <= bus.req_src1;
            cell_src2_q <= bus.req_src2;
            cell_en_q   <= 1'b1;
            cnt_q       <= 2'd0;
            req_ready_q <= 1'b0;
            state_q     <= ST_ISSUE_LO;
          end
        end
        ST_ISSUE_LO: begin
          if (cnt_q == LAT_LAST) begin
            cell_en_q <= 1'b0;
            state_q   <= ST_COMB_LO;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        ST_COMB_LO: begin
          mid_hi_q <= mid_hi_d;
          lo_c_q   <= lo_c_d;
          if (op_q == OP_MUL) begin
            rsp_data_q  <= lo_d;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            cell_src1_q <= swap_halves(src1_q);
            cell_src2_q <= swap_halves(src2_q);
            cell_en_q   <= 1'b1;
            cnt_q       <= 2'd0;
            state_q     <= ST_ISSUE_HI;
          end
        end
        ST_ISSUE_HI: begin
          if (cnt_q == LAT_LAST) begin
            cell_en_q <= 1'b0;
            cnt_q     <= 2'd0;
            state_q   <= ST_COMB_HI;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        ST_COMB_HI: begin
          // Two steps: register the unsigned high word, then apply the signed correction.
          if (cnt_q == 2'd0) begin
            hi_q  <= hi_raw_d;
            cnt_q <= 2'd1;
          end else begin
            rsp_data_q  <= hi_corr_d;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.cell_src1 = cell_src1_q;
  assign bus.cell_src2 = cell_src2_q;
  assign bus.cell_en   = cell_en_q;
endmodule

// File: tb/tb_nios_cpu_mult_seq.sv
// tb/tb_nios_cpu_mult_seq.sv - bench for nios_cpu_mult_seq with cell latencies 1 and 3 run in lockstep
module tb_nios_cpu_mult_seq;
  import nios_cpu_mult_seq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic        rsp_ready;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  nios_cpu_mult_seq_if bus1 ();
  nios_cpu_mult_seq_if bus3 ();

  assign bus1.req_valid = req_valid;
  assign bus1.req_op    = req_op;
  assign bus1.req_src1  = req_src1;
  assign bus1.req_src2  = req_src2;
  assign bus1.rsp_ready = rsp_ready;
  assign bus3.req_valid = req_valid;
  assign bus3.req_op    = req_op;
  assign bus3.req_src1  = req_src1;
  assign bus3.req_src2  = req_src2;
  assign bus3.rsp_ready = rsp_ready;

  nios_cpu_mult_seq #(.CELL_LATENCY(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));
  nios_cpu_mult_seq #(.CELL_LATENCY(3)) dut3 (.clk(clk), .reset_n(reset_n), .bus(bus3));

  // 16x16 cell: products {lo1*lo2, lo1*hi2, hi1*lo2}, pipeline advancing only with cell_en.
  function automatic logic [95:0] cell_fn(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] p1, p2, p3;
    p1 = {16'h0, a[15:0]}  * {16'h0, b[15:0]};
    p2 = {16'h0, a[15:0]}  * {16'h0, b[31:16]};
    p3 = {16'h0, a[31:16]} * {16'h0, b[15:0]};
    return {p1, p2, p3};
  endfunction

  logic [95:0] c1;
  logic [95:0] c3 [3];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c1 <= '0;
    end else if (bus1.cell_en) begin
      c1 <= cell_fn(bus1.cell_src1, bus1.cell_src2);
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c3[0] <= '0;
      c3[1] <= '0;
      c3[2] <= '0;
    end else if (bus3.cell_en) begin
      c3[0] <= cell_fn(bus3.cell_src1, bus3.cell_src2);
      c3[1] <= c3[0];
      c3[2] <= c3[1];
    end
  end

  assign bus1.cell_p1 = c1[95:64];
  assign bus1.cell_p2 = c1[63:32];
  assign bus1.cell_p3 = c1[31:0];
  assign bus3.cell_p1 = c3[2][95:64];
  assign bus3.cell_p2 = c3[2][63:32];
  assign bus3.cell_p3 = c3[2][31:0];

  // Reference: full 64-bit product of the (sign- or zero-extended) operands.
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] xa, xb, p;
    xa = {32'h0, a};
    xb = {32'h0, b};
    if (op == OP_MULXSU || op == OP_MULXSS) xa = {{32{a[31]}}, a};
    if (op == OP_MULXSS) xb = {{32{b[31]}}, b};
    p = xa * xb;
    return (op == OP_MUL) ? p[31:0] : p[63:32];
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input int l);
    return (op == OP_MUL) ? l + 1 : 2 * l + 3;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, " L1 req_ready"}, 32'(bus1.req_ready), 32'd1);
    check({tag, " L3 req_ready"}, 32'(bus3.req_ready), 32'd1);
    check({tag, " L1 rsp_valid"}, 32'(bus1.rsp_valid), 32'd0);
    check({tag, " L3 rsp_valid"}, 32'(bus3.rsp_valid), 32'd0);
    check({tag, " L1 rsp_data"},  bus1.rsp_data, 32'h0);
    check({tag, " L3 rsp_data"},  bus3.rsp_data, 32'h0);
    check({tag, " L1 cell_en"},   32'(bus1.cell_en), 32'd0);
    check({tag, " L3 cell_en"},   32'(bus3.cell_en), 32'd0);
    check({tag, " L1 cell_src1"}, bus1.cell_src1, 32'h0);
    check({tag, " L3 cell_src1"}, bus3.cell_src1, 32'h0);
    check({tag, " L1 cell_src2"}, bus1.cell_src2, 32'h0);
    check({tag, " L3 cell_src2"}, bus3.cell_src2, 32'h0);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit stall, input string name);
    int lat1, lat3, en1, en3;
    bit got1, got3;
    logic [31:0] s1_1, s2_1, s1_3, s2_3;
    logic [31:0] e1, e2;
    lat1 = 0; lat3 = 0; en1 = 0; en3 = 0; got1 = 0; got3 = 0;
    s1_1 = '0; s2_1 = '0; s1_3 = '0; s2_3 = '0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 2'($urandom); req_src1 = $urandom; req_src2 = $urandom;
    for (int e = 1; e <= 60 && !(got1 && got3); e++) begin
      if (!got1 && bus1.cell_en) begin en1++; s1_1 = bus1.cell_src1; s2_1 = bus1.cell_src2; end
      if (!got3 && bus3.cell_en) begin en3++; s1_3 = bus3.cell_src1; s2_3 = bus3.cell_src2; end
      @(posedge clk); #1;
      if (!got1 && bus1.rsp_valid) begin got1 = 1; lat1 = e; end
      if (!got3 && bus3.rsp_valid) begin got3 = 1; lat3 = e; end
    end
    check({name, " L1 response seen"}, 32'(got1), 32'd1);
    check({name, " L3 response seen"}, 32'(got3), 32'd1);
    check({name, " L1 rsp_data"}, bus1.rsp_data, exp);
    check({name, " L3 rsp_data"}, bus3.rsp_data, exp);
    check({name, " L1 latency"}, 32'(lat1), 32'(exp_lat(op, 1)));
    check({name, " L3 latency"}, 32'(lat3), 32'(exp_lat(op, 3)));
    check({name, " L1 cell_en cycles"}, 32'(en1), 32'((op == OP_MUL) ? 1 : 2));
    check({name, " L3 cell_en cycles"}, 32'(en3), 32'((op == OP_MUL) ? 3 : 6));
    e1 = (op == OP_MUL) ? a : {a[15:0], a[31:16]};
    e2 = (op == OP_MUL) ? b : {b[15:0], b[31:16]};
    check({name, " L1 last cell_src1"}, s1_1, e1);
    check({name, " L1 last cell_src2"}, s2_1, e2);
    check({name, " L3 last cell_src1"}, s1_3, e1);
    check({name, " L3 last cell_src2"}, s2_3, e2);
    if (stall) begin
      @(negedge clk);
      req_valid = 1'b1; req_op = OP_MUL; req_src1 = 32'h1234_5678; req_src2 = 32'h9abc_def0;
      for (int c = 0; c < 10; c++) begin
        @(posedge clk); #1;
        check({name, " stall L1 rsp_data"},  bus1.rsp_data, exp);
        check({name, " stall L3 rsp_data"},  bus3.rsp_data, exp);
        check({name, " stall L1 rsp_valid"}, 32'(bus1.rsp_valid), 32'd1);
        check({name, " stall L3 rsp_valid"}, 32'(bus3.rsp_valid), 32'd1);
        check({name, " stall L1 req_ready"}, 32'(bus1.req_ready), 32'd0);
        check({name, " stall L3 req_ready"}, 32'(bus3.req_ready), 32'd0);
        check({name, " stall L1 cell_en"},   32'(bus1.cell_en), 32'd0);
        check({name, " stall L3 cell_en"},   32'(bus3.cell_en), 32'd0);
      end
    end
    @(negedge clk);
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({name, " post L1 rsp_valid"}, 32'(bus1.rsp_valid), 32'd0);
    check({name, " post L3 rsp_valid"}, 32'(bus3.rsp_valid), 32'd0);
    check({name, " post L1 req_ready"}, 32'(bus1.req_ready), 32'd1);
    check({name, " post L3 req_ready"}, 32'(bus3.req_ready), 32'd1);
    if (stall) begin
      for (int c = 0; c < 3; c++) begin
        @(posedge clk); #1;
        check({name, " no accept L1 cell_en"}, 32'(bus1.cell_en), 32'd0);
        check({name, " no accept L3 cell_en"}, 32'(bus3.cell_en), 32'd0);
        check({name, " no accept L1 req_ready"}, 32'(bus1.req_ready), 32'd1);
      end
    end
  endtask

  // Abort a high-word op 'edges' clock edges after its accept with an asynchronous reset.
  task automatic reset_midflight(input int edges, input string name);
    int seen;
    seen = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_MULXUU; req_src1 = $urandom; req_src2 = $urandom;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (edges - 1) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_idle_reset(name);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (bus1.rsp_valid || bus3.rsp_valid) seen++;
    end
    rsp_ready = 1'b0;
    check({name, " discarded op produced no response"}, 32'(seen), 32'd0);
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    reset_n = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_src1 = '0; req_src2 = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_reset("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("idle L1 req_ready", 32'(bus1.req_ready), 32'd1);

    run_op(OP_MUL,    32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 1'b0, "mul_basic");
    run_op(OP_MULXUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, "mulxuu_ones");
    run_op(OP_MULXSS, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, "mulxss_ones");
    run_op(OP_MULXSS, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, "mulxss_min");
    run_op(OP_MULXSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b1, "mulxsu_stall");

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      if (i % 8 == 0) a = 32'h8000_0000 | (a & 32'h0000_FFFF);
      if (i % 8 == 1) b = 32'hFFFF_0000 | b;
      run_op(op, a, b, ref_mul(op, a, b), 1'b0, $sformatf("rand%0d op%0d", i, op));
    end

    reset_midflight(4, "rst_comb_hi_L1");
    run_op(OP_MUL, 32'd3, 32'd4, 32'h0000_000C, 1'b0, "mul_after_rst1");
    reset_midflight(8, "rst_comb_hi_L3");
    run_op(OP_MUL, 32'd3, 32'd4, 32'h0000_000C, 1'b0, "mul_after_rst3");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/nios_cpu_mult_seq.md
NIOS_CPU_MULT_SEQ -- requirements
Module: nios_cpu_mult_seq

Interface
REQ-001 SHALL have parameter CELL_LATENCY, default 1, range 1..3: clock edges from a cell_en-qualified operand to valid cell_p1..p3.
REQ-002 SHALL have port clk  input  1  sole clock, all state rising-edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  1  request present.
REQ-005 SHALL have port req_ready  output  1  request accepted when high with req_valid.
REQ-006 SHALL have port req_op  input  2  0=MUL (low word), 1=MULXUU, 2=MULXSU (src1 signed), 3=MULXSS (high word ops).
REQ-007 SHALL have ports req_src1 and req_src2  input  32 each  operands.
REQ-008 SHALL have ports cell_src1 and cell_src2  output  32 each  operands driven to the 16x16 partial-product cell.
REQ-009 SHALL have port cell_en  output  1  cell pipeline enable.
REQ-010 SHALL have ports cell_p1, cell_p2, cell_p3  input  32 each  cell products lo1*lo2, lo1*hi2, hi1*lo2.
REQ-011 SHALL have port rsp_valid  output  1  result present.
REQ-012 SHALL have port rsp_ready  input  1  result consumed when high with rsp_valid.
REQ-013 SHALL have port rsp_data  output  32  result word.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE_LO, COMB_LO, ISSUE_HI, COMB_HI, DONE.
REQ-015 SHALL assert req_ready only in IDLE; on accept it SHALL latch op/src1/src2 and go to ISSUE_LO.
REQ-016 In ISSUE_LO it SHALL drive cell_src1/2 = latched src1/src2, cell_en=1, for exactly CELL_LATENCY cycles, operands stable, then go to COMB_LO.
REQ-017 In COMB_LO it SHALL compute mid = p2+p3 (33 bits), lo = p1 + (mid[15:0]<<16) (33 bits), store lo[31:0] and carry terms; op MUL -> DONE with rsp_data = lo[31:0], else -> ISSUE_HI.
REQ-018 In ISSUE_HI it SHALL drive both operands with 16-bit halves swapped, cell_en=1, for CELL_LATENCY cycles, then go to COMB_HI.
REQ-019 In COMB_HI it SHALL compute hi = p1 + mid[32:16] + lo[32] mod 2^32 (unsigned high word), then apply signed correction, then go to DONE.
REQ-020 Signed correction SHALL be: MULXSU hi -= (src1[31] ? src2 : 0); MULXSS hi -= (src1[31] ? src2 : 0) + (src2[31] ? src1 : 0); all mod 2^32.
REQ-021 cell_en SHALL be 0 in IDLE, COMB_*, DONE; cell_src1/2 SHALL hold last value outside ISSUE states.
REQ-022 In DONE rsp_valid=1 and rsp_data SHALL stay stable until rsp_ready; on handshake -> IDLE (no same-cycle re-accept).
REQ-023 Latency (accept edge to rsp_valid high): MUL = CELL_LATENCY+1 edges; high ops = 2*CELL_LATENCY+3 edges (L=1: 2 and 5).
REQ-024 req_valid while busy SHALL be ignored (back-pressured); request inputs SHALL not be sampled outside IDLE.

Reset
REQ-025 reset_n low SHALL immediately force IDLE, req_ready=1 (after assertion), rsp_valid=0, rsp_data=0, cell_en=0, cell_src1/2=0, all latches 0.
REQ-026 Reset during any state SHALL discard the in-flight operation; no response SHALL ever be produced for it.

Structure
REQ-027 Shared package SHALL hold op encoding constants (MUL, MULXUU, MULXSU, MULXSS) and the FSM state enumeration.
REQ-028 Combine arithmetic (REQ-017/019/020) SHALL be one combinational sub-module nios_cpu_mult_pp_combine; FSM, latches, and handshake stay in top.

Verification
REQ-029 Bench SHALL model the cell with CELL_LATENCY pipeline gated by cell_en, run with L=1 and L=3.
REQ-030 MUL 0x00010003 * 0x00020005 -> rsp_data 0x000B000F, rsp_valid 2 edges after accept (L=1), cell_en high exactly 1 cycle.
REQ-031 MULXUU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE; MULXSS same operands -> 0x00000000; MULXSS 0x80000000 * 0x80000000 -> 0x40000000.
REQ-032 MULXSU 0xFFFFFFFF * 0x00000002 -> 0xFFFFFFFF; second pass cell_src1=0xFFFFFFFF, cell_src2=0x00020000.
REQ-033 rsp_ready held low 10 cycles in DONE -> rsp_data stable, req_ready 0, cell_en 0, new req_valid not accepted.
REQ-034 reset_n low in COMB_HI -> rsp_valid 0 same cycle, no response; after release MUL 3*4 -> 0x0000000C.
